ydriver_timing_gen: RTL and testbench

Generates the row-driver control signals S, CPL and FR for the LCD Y driver from the dot clock. A dot/line counter pair frames each line and each frame. Sits on the controller side of the panel interface, feeding the Y driver's S, CPL and FR inputs directly. The Y driver shifts the frame-start token S in on CPL, so this block keeps S stable across the entire first CPL pulse of every frame.

---
 rtl/ydriver_timing_gen_if.sv | 36 +++
 rtl/ydriver_timing_gen.sv | 142 ++++++++++++++
 tb/tb_ydriver_timing_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ydriver_timing_gen_if.sv
// ---------------------------------------------------------------------------
// ydriver_timing_gen_if
//
// Bundles the panel-side signals of the Y driver timing generator.
//
//   EN      panel drive enable (controller -> timing generator)
//   S       frame start token for the Y driver shift register
//   CPL     Y driver shift clock (one pulse per line)
//   FR      AC drive polarity
//   DOT     current dot index within the line
//   LINE    current line index within the frame
//   VBLANK  high while the current line is a blanking line
//
// Modports:
//   master  the side that drives EN and consumes the timing outputs
//   slave   the timing generator itself
// ---------------------------------------------------------------------------
interface ydriver_timing_gen_if;
  logic       EN;
  logic       S;
  logic       CPL;
  logic       FR;
  logic [8:0] DOT;
  logic [7:0] LINE;
  logic       VBLANK;

  modport master (
    output EN,
    input  S, CPL, FR, DOT, LINE, VBLANK
  );

  modport slave (
    input  EN,
    output S, CPL, FR, DOT, LINE, VBLANK
  );
endinterface

// File: rtl/ydriver_timing_gen.sv
// ---------------------------------------------------------------------------
// ydriver_timing_gen
//
// Generates the LCD Y driver row control signals S, CPL and FR from the dot
// clock.
//
// A dot counter (hcnt) frames each line.
// A line counter (vcnt) frames each frame.
// Every output is either a register or a direct decode of registers, so no
// input reaches an output without passing through a flop.
//
// Parameters:
//   H_TOTAL    dot clocks per line                    (2..512)
//   V_TOTAL    lines per frame including blanking     (2..256)
//   V_ACTIVE   visible lines                          (1..V_TOTAL)
//   CPL_WIDTH  CPL high time in dot clocks            (1..H_TOTAL-1)
//   FR_PERIOD  line wraps between FR toggles          (1..255)
//
// Ports:
//   CLK     dot clock; all state changes on its rising edge
//   n_RES   asynchronous active-low reset
//   bus     ydriver_timing_gen_if.slave: EN in; S, CPL, FR, DOT, LINE,
//           VBLANK out
// ---------------------------------------------------------------------------
module ydriver_timing_gen #(
  parameter int H_TOTAL   = 456,
  parameter int V_TOTAL   = 154,
  parameter int V_ACTIVE  = 144,
  parameter int CPL_WIDTH = 4,
  parameter int FR_PERIOD = 1
) (
  input  logic                CLK,
  input  logic                n_RES,
  ydriver_timing_gen_if.slave bus
);

  // Sized copies of the parameters so every compare is width-matched.
  // V_ACTIVE may be 256, so the blanking compare is done in 9 bits.
  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [7:0] V_LAST  = 8'(V_TOTAL - 1);
  localparam logic [7:0] FR_LAST = 8'(FR_PERIOD - 1);
  localparam logic [8:0] CPL_W   = 9'(CPL_WIDTH);
  localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [8:0] hcnt_q;
  logic [8:0] hcnt_d;
  logic [7:0] vcnt_q;
  logic [7:0] vcnt_d;
  logic [7:0] frcnt_q;
  logic [7:0] frcnt_d;
  logic       fr_q;
  logic       fr_d;
  logic       line_wrap;
  logic       running;

  // State register.
  // Reset forces the idle state at once, without waiting for a clock edge.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frcnt_q <= '0;
      fr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frcnt_q <= frcnt_d;
      fr_q    <= fr_d;
    end
  end

  assign line_wrap = (hcnt_q == H_LAST);

  // Next-state logic.
  // Dropping EN abandons the frame on that very edge; there is no
  // completion of a partial line.
  // On start-up the counters begin at line 0, dot 0, so the first edge
  // with EN high already presents S and CPL.
  // FR is a free-running polarity: it survives the frame wrap and is only
  // cleared by going idle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frcnt_d = frcnt_q;
    fr_d    = fr_q;

    if (!bus.EN) begin
      state_d = IDLE;
      hcnt_d  = '0;
      vcnt_d  = '0;
      frcnt_d = '0;
      fr_d    = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = RUN;
      hcnt_d  = '0;
      vcnt_d  = '0;
      frcnt_d = '0;
    end else begin
      state_d = RUN;
      if (!line_wrap) begin
        hcnt_d = hcnt_q + 9'd1;
      end else begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? 8'd0 : vcnt_q + 8'd1;
        if (frcnt_q == FR_LAST) begin
          frcnt_d = '0;
          fr_d    = ~fr_q;
        end else begin
          frcnt_d = frcnt_q + 8'd1;
        end
      end
    end
  end

  assign running = (state_q == RUN);

  // Output decode.
  // S is a line-0 decode, so it rises with the line-0 CPL pulse and falls
  // with the line-1 CPL rise. That keeps S stable across both edges of the
  // first CPL pulse of every frame.
  // CPL keeps pulsing through blanking so the token is shifted past the
  // last row.
  always_comb begin
    bus.CPL    = running && (hcnt_q < CPL_W);
    bus.S      = running && (vcnt_q == 8'd0);
    bus.VBLANK = running && ({1'b0, vcnt_q} >= V_ACT);
    bus.FR     = fr_q;
    bus.DOT    = hcnt_q;
    bus.LINE   = vcnt_q;
  end

endmodule

// File: tb/tb_ydriver_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_ydriver_timing_gen
//
// Three instances of the timing generator share the clock and reset:
//   dut_a  default geometry; start-up and full-frame behaviour
//   dut_b  small geometry (8 x 4, FR_PERIOD=3) under random EN
//   dut_c  default geometry; used for the mid-frame abort
//
// Every instance is compared on every falling clock edge against a
// reference model. The model tracks only "running" and the number of edges
// since start. It derives the dot, line and polarity from those values with
// division and modulo.
// ---------------------------------------------------------------------------
module tb_ydriver_timing_gen;

  logic clk;
  logic n_res;
  logic mon_on;
  logic rand_done;

  int tests_run;
  int tests_failed;

  ydriver_timing_gen_if bus_a ();
  ydriver_timing_gen_if bus_b ();
  ydriver_timing_gen_if bus_c ();

  ydriver_timing_gen dut_a (
    .CLK   (clk),
    .n_RES (n_res),
    .bus   (bus_a)
  );

  ydriver_timing_gen #(
    .H_TOTAL   (8),
    .V_TOTAL   (4),
    .V_ACTIVE  (3),
    .CPL_WIDTH (2),
    .FR_PERIOD (3)
  ) dut_b (
    .CLK   (clk),
    .n_RES (n_res),
    .bus   (bus_b)
  );

  ydriver_timing_gen dut_c (
    .CLK   (clk),
    .n_RES (n_res),
    .bus   (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {S, CPL, FR, VBLANK, DOT, LINE}.
  logic [20:0] obs_a;
  logic [20:0] obs_b;
  logic [20:0] obs_c;
  assign obs_a = {bus_a.S, bus_a.CPL, bus_a.FR, bus_a.VBLANK, bus_a.DOT, bus_a.LINE};
  assign obs_b = {bus_b.S, bus_b.CPL, bus_b.FR, bus_b.VBLANK, bus_b.DOT, bus_b.LINE};
  assign obs_c = {bus_c.S, bus_c.CPL, bus_c.FR, bus_c.VBLANK, bus_c.DOT, bus_c.LINE};

  logic [2:0] en_s;
  assign en_s = {bus_c.EN, bus_b.EN, bus_a.EN};

  // Reference model state: running flag and edges elapsed since start.
  bit run_m [3];
  int t_m   [3];

  always @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      for (int k = 0; k < 3; k++) begin
        run_m[k] <= 1'b0;
        t_m[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!en_s[k]) begin
          run_m[k] <= 1'b0;
          t_m[k]   <= 0;
        end else if (!run_m[k]) begin
          run_m[k] <= 1'b1;
          t_m[k]   <= 0;
        end else begin
          t_m[k] <= t_m[k] + 1;
        end
      end
    end
  end

  // Expected outputs t edges after start.
  // The line wraps completed so far are t / h. FR flips once every fp wraps.
  function automatic logic [20:0] expected_outputs(input bit run, input int t,
                                                   input int h, input int v,
                                                   input int va, input int cw,
                                                   input int fp);
    int dot;
    int wraps;
    int line;
    if (!run) return '0;
    dot   = t % h;
    wraps = t / h;
    line  = wraps % v;
    return {(line == 0), (dot < cw), ((wraps / fp) % 2 == 1), (line >= va),
            9'(dot), 8'(line)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Continuous comparison of all three instances against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("mon_a", 32'(obs_a), 32'(expected_outputs(run_m[0], t_m[0], 456, 154, 144, 4, 1)));
      checkOutput("mon_b", 32'(obs_b), 32'(expected_outputs(run_m[1], t_m[1], 8, 4, 3, 2, 3)));
      checkOutput("mon_c", 32'(obs_c), 32'(expected_outputs(run_m[2], t_m[2], 456, 154, 144, 4, 1)));
    end
  end

  // Random EN on the small instance: mostly high, with occasional drops.
  task automatic applyStimulus();
    while (!rand_done) begin
      @(negedge clk);
      bus_b.EN = ($urandom_range(0, 63) != 0);
    end
  endtask

  // Start-up and one full frame on dut_a.
  task automatic run_frame_a();
    int  cpl_rises;
    int  s_pulses;
    int  s_cycles;
    int  vb_cycles;
    int  vb_first_line;
    int  fr_toggles;
    int  fr_at_rise;
    bit  prev_cpl;
    bit  prev_s;
    bit  prev_fr;
    bit  prev_vb;
    cpl_rises = 0; s_pulses = 0; s_cycles = 0; vb_cycles = 0;
    vb_first_line = -1; fr_toggles = 0; fr_at_rise = 0;
    prev_cpl = 0; prev_s = 0; prev_fr = 0; prev_vb = 0;

    bus_a.EN = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 70224; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0)   checkOutput("startup",   32'(obs_a), 32'({4'b1100, 9'd0, 8'd0}));
      if (i == 4)   checkOutput("cpl_fall",  32'(obs_a), 32'({4'b1000, 9'd4, 8'd0}));
      if (i == 456) checkOutput("line1_cpl", 32'(obs_a), 32'({4'b0110, 9'd0, 8'd1}));
      if (bus_a.CPL && !prev_cpl) cpl_rises++;
      if (bus_a.S) s_cycles++;
      if (bus_a.S && !prev_s) s_pulses++;
      if (bus_a.VBLANK) begin
        vb_cycles++;
        if (!prev_vb) vb_first_line = int'(bus_a.LINE);
      end
      if (i > 0 && bus_a.FR != prev_fr) begin
        fr_toggles++;
        if (bus_a.CPL && !prev_cpl) fr_at_rise++;
      end
      prev_cpl = bus_a.CPL;
      prev_s   = bus_a.S;
      prev_fr  = bus_a.FR;
      prev_vb  = bus_a.VBLANK;
    end
    checkOutput("cpl_pulses",    32'(cpl_rises),     32'd154);
    checkOutput("s_pulses",      32'(s_pulses),      32'd1);
    checkOutput("s_width",       32'(s_cycles),      32'd456);
    checkOutput("vblank_cycles", 32'(vb_cycles),     32'd4560);
    checkOutput("vblank_start",  32'(vb_first_line), 32'd144);
    checkOutput("fr_toggles",    32'(fr_toggles),    32'd153);
    checkOutput("fr_at_cpl",     32'(fr_at_rise),    32'd153);
    @(negedge clk);
    checkOutput("frame_wrap",    32'(obs_a), 32'({4'b1100, 9'd0, 8'd0}));
  endtask

  // Mid-frame abort and restart on dut_c.
  task automatic run_abort_c();
    bit found;
    found = 0;
    bus_c.EN = 1'b1;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(negedge clk);
      if (bus_c.LINE == 8'd50 && bus_c.DOT == 9'd200) found = 1;
    end
    checkOutput("abort_reach", 32'(found), 32'd1);
    if (found) begin
      bus_c.EN = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle", 32'(obs_c), 32'd0);
      bus_c.EN = 1'b1;
      @(negedge clk);
      checkOutput("restart", 32'(obs_c), 32'({4'b1100, 9'd0, 8'd0}));
    end
  endtask

  // Asynchronous reset pulsed between clock edges while CPL is high.
  task automatic run_async_reset();
    bit found;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (bus_a.CPL) found = 1;
    end
    checkOutput("cpl_seen", 32'(found), 32'd1);
    #2 n_res = 1'b0;
    #1;
    checkOutput("async_rst_a", 32'(obs_a), 32'd0);
    checkOutput("async_rst_b", 32'(obs_b), 32'd0);
    checkOutput("async_rst_c", 32'(obs_c), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_res = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mon_on       = 1'b0;
    rand_done    = 1'b0;
    n_res        = 1'b0;
    bus_a.EN     = 1'b0;
    bus_b.EN     = 1'b0;
    bus_c.EN     = 1'b0;

    #12;
    checkOutput("reset_a", 32'(obs_a), 32'd0);
    checkOutput("reset_b", 32'(obs_b), 32'd0);

    @(negedge clk);
    n_res  = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 999) checkOutput("idle_a", 32'(obs_a), 32'd0);
    end

    fork
      applyStimulus();
      begin
        fork
          run_frame_a();
          run_abort_c();
        join
        run_async_reset();
        repeat (50) @(negedge clk);
        rand_done = 1'b1;
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
